timer_sched: RTL and testbench

- Sequencer and arbiter for one shared down-counting timer of the counter family: load, enable, countdown controls plus a count value readback.
- Up to NUM_REQ requesters, such as game-logic delay channels, each request a one-shot delay of a given tick count.
- The block grants one requester at a time (round-robin), loads and runs the counter, and pulses that requester's done when the count reaches 0.
- Sits between the requesting control FSMs and a single counter instance.

---
 rtl/timer_sched_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/timer_sched.sv | 138 +++++++++++++
 tb/tb_timer_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// timer_sched shared types and default sizes.
// State encoding for the one-shot timer sequencer.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_COUNT_WIDTH = 8;
  localparam int DEF_MAXCOUNT    = 255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Searches req from last+1 upward with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      idx,
  output logic [NUM_REQ-1:0] onehot
);

  // First requester after the previous owner wins
  always_comb begin
    int c;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    c      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last) + k) % NUM_REQ;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = c[IW-1:0];
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/timer_sched.sv
// Round-robin sequencer for one shared down-counter.
// Optional abort input/output: TIMER_SCHED_ABORT_EN.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int MAXCOUNT    = DEF_MAXCOUNT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] duration,
  input  logic                           tick,
  input  logic [COUNT_WIDTH-1:0]         cnt_value,
`ifdef TIMER_SCHED_ABORT_EN
  input  logic                           abort,
  output logic [NUM_REQ-1:0]             aborted,
`endif
  output logic                           cnt_load,
  output logic [COUNT_WIDTH-1:0]         cnt_load_number,
  output logic                           cnt_enable,
  output logic                           cnt_countdown,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                   state;
  logic [IW-1:0]            last;
  logic [IW-1:0]            idx;
  logic                     pick_valid;
  logic [IW-1:0]            pick_idx;
  logic [NUM_REQ-1:0]       pick_onehot;
  logic [COUNT_WIDTH-1:0]   pick_dur;
  logic [COUNT_WIDTH-1:0]   pick_clamp;
  logic [COUNT_WIDTH-1:0]   dur_arr [NUM_REQ];
  logic                     kill;

`ifdef TIMER_SCHED_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dur
    assign dur_arr[g] =
      duration[g*COUNT_WIDTH +: COUNT_WIDTH];
  end

  assign pick_dur = dur_arr[pick_idx];

  if (MAXCOUNT < (2**COUNT_WIDTH) - 1) begin : g_clamp
    localparam logic [COUNT_WIDTH-1:0] MAXV =
      COUNT_WIDTH'(MAXCOUNT);
    assign pick_clamp =
      (pick_dur > MAXV) ? MAXV : pick_dur;
  end else begin : g_noclamp
    assign pick_clamp = pick_dur;
  end

  // Count only on ticks and stop at 0 so the counter never wraps
  assign cnt_enable = (state == ST_RUN) && tick &&
                      (cnt_value != '0);

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      last            <= IW'(NUM_REQ - 1);
      idx             <= '0;
      grant           <= '0;
      done            <= '0;
      busy            <= 1'b0;
      cnt_load        <= 1'b0;
      cnt_load_number <= '0;
      cnt_countdown   <= 1'b1;
`ifdef TIMER_SCHED_ABORT_EN
      aborted         <= '0;
`endif
    end else begin
      done          <= '0;
      cnt_load      <= 1'b0;
      cnt_countdown <= 1'b1;
`ifdef TIMER_SCHED_ABORT_EN
      aborted       <= '0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state           <= ST_LOAD;
            idx             <= pick_idx;
            grant           <= pick_onehot;
            cnt_load_number <= pick_clamp;
            cnt_load        <= 1'b1;
            busy            <= 1'b1;
          end
        end
        ST_LOAD, ST_RUN: begin
          if (kill) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            last  <= idx;
`ifdef TIMER_SCHED_ABORT_EN
            aborted <= grant;
`endif
          end else if (state == ST_LOAD) begin
            state <= ST_RUN;
          end else if (cnt_value == '0) begin
            state <= ST_DONE;
            done  <= grant;
            grant <= '0;
            last  <= idx;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Randomized bench for timer_sched against a job-level model.
// Drives a behavioural counter from cnt_load/cnt_enable.
module tb_timer_sched;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXC = 200;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req;
  logic [N*W-1:0] duration;
  logic           tick;
  logic [W-1:0]   cnt_val;
  logic           cnt_load;
  logic [W-1:0]   cnt_load_number;
  logic           cnt_enable;
  logic           cnt_countdown;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
`ifdef TIMER_SCHED_ABORT_EN
  logic           abort;
  logic [N-1:0]   aborted;
`endif

  timer_sched #(
    .NUM_REQ     (N),
    .COUNT_WIDTH (W),
    .MAXCOUNT    (MAXC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .duration        (duration),
    .tick            (tick),
    .cnt_value       (cnt_val),
`ifdef TIMER_SCHED_ABORT_EN
    .abort           (abort),
    .aborted         (aborted),
`endif
    .cnt_load        (cnt_load),
    .cnt_load_number (cnt_load_number),
    .cnt_enable      (cnt_enable),
    .cnt_countdown   (cnt_countdown),
    .grant           (grant),
    .done            (done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Counter instance stand-in, wraps to MAXC going down
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_val <= '0;
    else if (cnt_load) cnt_val <= cnt_load_number;
    else if (cnt_enable) begin
      if (cnt_countdown)
        cnt_val <= (cnt_val == 0) ? W'(MAXC) : cnt_val - 1;
      else
        cnt_val <= (cnt_val == W'(MAXC)) ? '0 : cnt_val + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int en_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Job-level model: one active job, its phase, rr pointer
  bit           m_act, m_run, m_fin;
  int           m_ch, m_dur, m_last;
  logic [N-1:0] m_abt;

  task automatic m_reset();
    m_act = 0; m_run = 0; m_fin = 0;
    m_ch = 0; m_dur = 0; m_last = N - 1;
    m_abt = '0;
  endtask

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic bit ab_now();
`ifdef TIMER_SCHED_ABORT_EN
    return abort;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_pick();
    int best, bd, d, v;
    best = -1; bd = N;
    for (int c = 0; c < N; c++) begin
      d = (c - m_last - 1 + 2 * N) % N;
      if (req[c] && d < bd) begin
        bd = d; best = c;
      end
    end
    v = int'(duration[best*W +: W]);
    m_ch  = best;
    m_dur = (v > MAXC) ? MAXC : v;
    m_act = 1; m_run = 0; m_fin = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_load_num", cnt_load_number, 0);
    chk("rst_enable", cnt_enable, 0);
    chk("rst_countdown", cnt_countdown, 1);
`ifdef TIMER_SCHED_ABORT_EN
    chk("rst_aborted", aborted, 0);
`endif
  endtask

  // Check current outputs, advance model and clock one cycle
  task automatic cycle();
    logic [N-1:0] eg, ed;
    bit el, ee;
    #1;
    eg = (m_act && !m_fin) ? oh(m_ch) : '0;
    ed = (m_act && m_fin) ? oh(m_ch) : '0;
    el = m_act && !m_run && !m_fin;
    ee = m_act && m_run && !m_fin && tick &&
         (cnt_val != 0);
    chk("grant", grant, eg);
    chk("done", done, ed);
    chk("busy", busy, m_act);
    chk("load", cnt_load, el);
    if (el) chk("load_num", cnt_load_number, m_dur);
    chk("countdown", cnt_countdown, 1);
    chk("enable", cnt_enable, ee);
`ifdef TIMER_SCHED_ABORT_EN
    chk("aborted", aborted, m_abt);
`endif
    if (cnt_enable) en_cnt++;
    m_abt = '0;
    if (!m_act) begin
      if (req != 0) m_pick();
    end else if (m_fin) begin
      m_act = 0; m_fin = 0; m_last = m_ch;
    end else if (ab_now()) begin
      m_act = 0; m_last = m_ch; m_abt = oh(m_ch);
    end else if (!m_run) begin
      m_run = 1;
    end else if (cnt_val == 0) begin
      m_fin = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle_wait();
    req = '0;
    tick = 1'b1;
`ifdef TIMER_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    for (int k = 0; k < 600 && m_act; k++) cycle();
    chk("idle_wait", busy, 0);
  endtask

  task automatic latency(input int ch, input int d);
    int k;
    idle_wait();
    req[ch] = 1'b1;
    duration[ch*W +: W] = W'(d);
    k = 0;
    do begin
      cycle();
      k++;
      req = '0;
      duration = $urandom;
    end while (!done[ch] && k < 300);
    chk("latency", k, d + 3);
  endtask

  initial begin
    int got[$];
    int tlast, k;
    m_reset();
    req = '0;
    duration = '0;
    tick = 1'b0;
`ifdef TIMER_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b1;

    latency(0, 5);
    latency(2, 0);

    // Sparse tick: one tick every 4th cycle
    idle_wait();
    req = 4'b0010;
    duration[1*W +: W] = 8'd3;
    en_cnt = 0;
    k = 0;
    do begin
      tick = (k % 4 == 3);
      cycle();
      k++;
      req = '0;
    end while (!done[1] && k < 100);
    chk("sparse_en", en_cnt, 3);

    // Round-robin from reset, all held, duration 1
    idle_wait();
    do_reset();
    req = 4'b1111;
    duration = {4{8'd1}};
    tick = 1'b1;
    tlast = 0;
    for (int i = 0; i < 80 && got.size() < 5; i++) begin
      cycle();
      if (done != 0) begin
        for (int c = 0; c < N; c++)
          if (done[c]) got.push_back(c);
        if (got.size() > 1) chk("rr_gap", cyc - tlast, 5);
        tlast = cyc;
      end
    end
    chk("rr_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++)
      chk("rr_order", got[i], i % N);

    // Reset while counting, then priority from reset
    idle_wait();
    req = 4'b1000;
    duration[3*W +: W] = 8'd6;
    cycle();
    req = '0;
    for (int i = 0; i < 50 && !(m_run && cnt_val == 2); i++)
      cycle();
    chk("mid_cnt", cnt_val, 2);
    do_reset();
    chk("post_rst_cnt", cnt_val, 0);
    req = 4'b1001;
    cycle();
    chk("post_rst_grant", grant, 4'b0001);
    idle_wait();

`ifdef TIMER_SCHED_ABORT_EN
    do_reset();
    req = 4'b1100;
    duration[2*W +: W] = 8'd5;
    duration[3*W +: W] = 8'd5;
    tick = 1'b1;
    cycle();
    cycle();
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_pulse", aborted, 4'b0100);
    chk("abort_nodone", done, 0);
    chk("abort_idle", busy, 0);
    cycle();
    chk("abort_next", grant, 4'b1000);
    idle_wait();
`endif

    // Randomized traffic, including clamped durations
    for (int i = 0; i < 3000; i++) begin
      req = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int c = 0; c < N; c++)
        duration[c*W +: W] = ($urandom % 16 == 0) ?
          W'($urandom) : W'($urandom % 8);
      tick = ($urandom % 4 != 0);
`ifdef TIMER_SCHED_ABORT_EN
      abort = ($urandom % 40 == 0);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
